// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared widths, pending counter type and zero-register index
package reg_file_sb_pkg;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG           = 0;

  typedef logic [1:0] pend_cnt_t;
  localparam pend_cnt_t CNT_MAX = 2'd3;
endpackage

// File: rtl/reg_pending_ctr.sv
// rtl/reg_pending_ctr.sv - saturating up/down count of outstanding writes for one register
module reg_pending_ctr
  import reg_file_sb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      inc_i,
  input  logic      dec_i,
  output pend_cnt_t cnt_o
);
  pend_cnt_t cnt_q, cnt_d;

  // Simultaneous issue and retire cancel; neither direction wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 2'd1;
    else if (dec_i && !inc_i && cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write-through reads and per-register pending-write scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  input  logic                      iss_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd_i,
  output logic                      iss_ready_o,
  input  logic                      wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic                      wb_ready_o,
  output logic                      err_o
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  pend_cnt_t             cnt [NREG];
  logic                  err_q, err_d;
  logic                  iss_fire, wb_fire;

  assign wb_ready_o  = rst_ni;
  assign wb_fire     = wb_valid_i && wb_ready_o;
  assign iss_ready_o = rst_ni && ((iss_rd_i == ZERO_IDX) || (cnt[iss_rd_i] != CNT_MAX) ||
                                  (wb_valid_i && wb_rd_i == iss_rd_i));
  assign iss_fire    = iss_valid_i && iss_ready_o && (iss_rd_i != ZERO_IDX);

  assign cnt[0] = '0;
  for (genvar i = 1; i < NREG; i++) begin : g_ctr
    reg_pending_ctr u_ctr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (iss_fire && iss_rd_i == REG_ADDR_WIDTH'(i)),
      .dec_i  (wb_fire && wb_rd_i == REG_ADDR_WIDTH'(i)),
      .cnt_o  (cnt[i])
    );
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (addr == ZERO_IDX)                   return '0;
    else if (wb_fire && wb_rd_i == addr)    return wb_data_i;
    else                                    return regs_q[addr];
  endfunction

  // A retiring last pending write makes the bypassed data valid this cycle.
  function automatic logic read_busy(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (!rst_ni || cnt[addr] == 2'd0)                         return 1'b0;
    else if (wb_fire && wb_rd_i == addr && cnt[addr] == 2'd1) return 1'b0;
    else                                                      return 1'b1;
  endfunction

  assign rs1_data_o = read_port(rs1_addr_i);
  assign rs2_data_o = read_port(rs2_addr_i);
  assign rs1_busy_o = read_busy(rs1_addr_i);
  assign rs2_busy_o = read_busy(rs2_addr_i);

  // An unmatched retire is flagged unless an issue to the same index pairs with it.
  always_comb begin
    err_d = err_q;
    if (wb_fire && wb_rd_i != ZERO_IDX && cnt[wb_rd_i] == 2'd0 &&
        !(iss_fire && iss_rd_i == wb_rd_i))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      if (wb_fire && wb_rd_i != ZERO_IDX) regs_q[wb_rd_i] <= wb_data_i;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
endmodule
